// File: rtl/led_uart_pkg.sv
// Shared types and constants for the LED-to-UART reporter.
package led_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;

endpackage

// File: rtl/led_uart_reporter_sync_fifo.sv
// Small synchronous FIFO with a combinational head. The read and write
// pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care while the pointers say empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/led_uart_reporter.sv
// Watches the CPU LED bus, queues every new value and sends each one out
// as an 8N1 UART frame so firmware progress can be logged off-chip.
module led_uart_reporter
    import led_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    led,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int               CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic [7:0]    led_q, led_d;
    logic          overflow_q, overflow_d;
    tx_state_t     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;

    logic          led_change;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (led_change),
        .push_data (led),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign led_change = (led != led_q);
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
    assign tx         = tx_q;

    // Change detector and sticky overflow; a drop only happens when full with no pop.
    always_comb begin
        led_d      = led;
        overflow_d = overflow_q;
        if (led_change && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    // TX FSM next state: one bit period per state visit, eight visits of DATA.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        fifo_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Line level decoded from the next state so the registered pin moves with the state.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // State registers; reset aborts any frame in flight and returns the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q      <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= UART_IDLE_LEVEL;
        end else begin
            led_q      <= led_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

endmodule
